ahb2apb_xfer_sched: RTL
=======================

Name: ahb2apb_xfer_sched

Overview:
Parametrised transfer scheduler for the AHB-to-APB bridge. It arbitrates between a pending AHB read and the head of the posted-write FIFO, using a configurable priority and a fairness limit. It latches the address and size of the winner and issues exactly one start pulse per transfer. It then stays busy until the APB side reports completion, so at most one transfer is in flight.

Parameters:
AHB_AW, 32, address width
READ_PRIORITY, 0, 0 = writes win ties (default ordering), 1 = reads win ties
MAX_CONSEC, 4, maximum consecutive priority-side grants while the other side waits; 0 = pure priority, no fairness

Ports:
hclk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_hready  in  1  AHB side stable; arbitration allowed only when 1
i_read_req  in  1  read pending; level, held by requester until o_read_grant
i_haddr_read  in  AHB_AW  read address
i_hsize_read  in  3  read size
i_fifo_empty  in  1  posted-write FIFO empty
i_haddr_write  in  AHB_AW  FIFO head address
i_hsize_write  in  3  FIFO head size
i_xfer_done  in  1  one-cycle pulse from APB master: current transfer finished
o_start_transfer  out  1  one-cycle start pulse
o_hwrite  out  1  direction of latched transfer (1 = write)
o_haddr  out  AHB_AW  latched address, stable from start until done
o_hsize  out  3  latched size
o_fifo_pop  out  1  one-cycle pop of FIFO head; coincides with a write start
o_read_grant  out  1  one-cycle acknowledge of read; coincides with a read start
o_busy  out  1  transfer in flight

Behaviour:
- Clock and reset: one clock, hclk. Reset is asynchronous and active-low on rst_n. All state registers are reset.
- Reset values: state IDLE; every output 0, including o_haddr and o_hsize; fairness counter 0.
- FSM states: IDLE, START, WAIT.
- IDLE:
  - Arbitrate when i_hready=1 and (i_read_req=1 or i_fifo_empty=0); otherwise stay in IDLE.
  - Winner rules:
    - Only one side pending: that side wins.
    - Both pending, counter < MAX_CONSEC or MAX_CONSEC=0: the priority side wins.
    - Both pending, counter == MAX_CONSEC (MAX_CONSEC>0): the non-priority side wins.
  - On a grant: register o_haddr, o_hsize, o_hwrite from the winner's inputs and go to START.
- START (exactly one cycle):
  - o_start_transfer=1 and o_busy=1.
  - o_fifo_pop=1 if o_hwrite=1; otherwise o_read_grant=1.
  - Always go to WAIT.
- WAIT:
  - o_busy=1; address, size and direction are held.
  - On i_xfer_done=1 go to IDLE and drop o_busy in the next cycle.
- Latency and throughput:
  - A request sampled in IDLE at edge N gives the start pulse in cycle N+1.
  - Minimum period is 3 cycles per transfer (IDLE, START, WAIT with immediate done).
- Fairness counter:
  - Width is clog2(MAX_CONSEC+1).
  - Increments, saturating, when the priority side is granted while the other side is pending.
  - Clears when the non-priority side is granted.
  - Unchanged when the priority side is granted alone.
- Boundary conditions:
  - i_xfer_done in IDLE or START: ignored.
  - Done and a new request in the same cycle: the request is evaluated in IDLE on the following cycle, with no combinational bypass.
  - i_hready low in IDLE: no grant; counter unchanged.
  - A read request withdrawn before grant is a protocol violation. Requests are sampled only in IDLE, so a withdrawn request is simply not granted.
  - FIFO becoming empty during WAIT: no effect.
  - Reset mid-operation (START or WAIT): immediate return to IDLE. No pop or grant pulse is produced; the FIFO head stays unpopped.
  - MAX_CONSEC=0: the counter is removed (constant 0) and arbitration is pure priority.

Decomposition:
- Shared package (ahb2apb_pkg): FSM state encoding (IDLE=2'd0, START=2'd1, WAIT=2'd2) and HSIZE constants (BYTE=3'd0, HALF=3'd1, WORD=3'd2).
- One sub-module, ahb2apb_fair_cnt: saturating counter with inc/clr/limit-reached outputs, parametrised by MAX_CONSEC.
- The FSM and the output register bank stay in the top module.

Test Plan:
- Single write: fifo_empty=0, haddr_write=0x4000_0010, hsize=2, hready=1, done 2 cycles after start -> start, pop, hwrite=1 in one cycle; busy for 3 cycles; o_haddr=0x4000_0010 held throughout.
- Single read: read_req=1, haddr_read=0x4000_0020 -> start and read_grant pulse together, hwrite=0; no pop.
- Tie, READ_PRIORITY=0, MAX_CONSEC=2, both sides always pending, done 1 cycle after each start -> grant order W, W, R, W, W, R; counter returns to 0 after each R.
- MAX_CONSEC=0, READ_PRIORITY=1, both pending for 5 transfers -> all 5 are reads; no pop.
- Reset asserted in WAIT with done never arriving -> all outputs 0 immediately; after release with fifo_empty=0, exactly one new pop and start.
- hready=0 with requests pending for 4 cycles -> no start; start occurs 1 cycle after hready rises. Done pulsed in IDLE -> no effect.

Source files
------------

// File: rtl/ahb2apb_pkg.sv
// Shared definitions for the AHB-to-APB bridge transfer scheduler.
// Holds the FSM state encoding, HSIZE codes and the winner-selection rule.
package ahb2apb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // With both sides pending, the priority side wins unless the fairness limit is hit.
  function automatic logic pick_write(input logic rd_pend,
                                      input logic wr_pend,
                                      input logic read_prio,
                                      input logic limit);
    if (!rd_pend) return 1'b1;
    if (!wr_pend) return 1'b0;
    return read_prio ? limit : !limit;
  endfunction

endpackage

// File: rtl/ahb2apb_fair_cnt.sv
// Saturating count of consecutive priority-side grants taken while the other side waited.
// With MAX_CONSEC=0 the count is held at zero and the limit never fires.
module ahb2apb_fair_cnt #(
  parameter int MAX_CONSEC = 4
) (
  input  logic hclk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic o_limit
);

  localparam int CW = (MAX_CONSEC > 0) ? $clog2(MAX_CONSEC + 1) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign o_limit = (MAX_CONSEC != 0) && (cnt_q == CW'(MAX_CONSEC));

  always_comb begin
    cnt_d = cnt_q;
    if ((MAX_CONSEC == 0) || clr) begin
      cnt_d = '0;
    end else if (inc && !o_limit) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ahb2apb_xfer_sched.sv
// Transfer scheduler: arbitrates a pending AHB read against the posted-write FIFO head,
// latches the winner and keeps exactly one APB transfer in flight.
module ahb2apb_xfer_sched
  import ahb2apb_pkg::*;
#(
  parameter int AHB_AW        = 32,
  parameter int READ_PRIORITY = 0,
  parameter int MAX_CONSEC    = 4
) (
  input  logic              hclk,
  input  logic              rst_n,
  input  logic              i_hready,
  input  logic              i_read_req,
  input  logic [AHB_AW-1:0] i_haddr_read,
  input  logic [2:0]        i_hsize_read,
  input  logic              i_fifo_empty,
  input  logic [AHB_AW-1:0] i_haddr_write,
  input  logic [2:0]        i_hsize_write,
  input  logic              i_xfer_done,
  output logic              o_start_transfer,
  output logic              o_hwrite,
  output logic [AHB_AW-1:0] o_haddr,
  output logic [2:0]        o_hsize,
  output logic              o_fifo_pop,
  output logic              o_read_grant,
  output logic              o_busy
);

  localparam logic READ_PRIO = (READ_PRIORITY != 0);

  state_e            state_q, state_d;
  logic [AHB_AW-1:0] haddr_q, haddr_d;
  logic [2:0]        hsize_q, hsize_d;
  logic              hwrite_q, hwrite_d;

  logic rd_pend, wr_pend, both_pend, arb;
  logic win_write, prio_win;
  logic cnt_inc, cnt_clr, cnt_limit;

  always_comb begin
    rd_pend   = i_read_req;
    wr_pend   = !i_fifo_empty;
    both_pend = rd_pend && wr_pend;
    arb       = (state_q == IDLE) && i_hready && (rd_pend || wr_pend);
    win_write = pick_write(rd_pend, wr_pend, READ_PRIO, cnt_limit);
    prio_win  = (win_write != READ_PRIO);
    cnt_inc   = arb && both_pend && prio_win;
    cnt_clr   = arb && !prio_win;
  end

  ahb2apb_fair_cnt #(
    .MAX_CONSEC (MAX_CONSEC)
  ) u_fair_cnt (
    .hclk    (hclk),
    .rst_n   (rst_n),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .o_limit (cnt_limit)
  );

  // Requests are only looked at in IDLE, so done and a new request never short-circuit.
  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hsize_d  = hsize_q;
    hwrite_d = hwrite_q;
    case (state_q)
      IDLE: begin
        if (arb) begin
          state_d  = START;
          hwrite_d = win_write;
          haddr_d  = win_write ? i_haddr_write : i_haddr_read;
          hsize_d  = win_write ? i_hsize_write : i_hsize_read;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (i_xfer_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      haddr_q  <= '0;
      hsize_q  <= HSIZE_BYTE;
      hwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hsize_q  <= hsize_d;
      hwrite_q <= hwrite_d;
    end
  end

  assign o_start_transfer = (state_q == START);
  assign o_fifo_pop       = o_start_transfer && hwrite_q;
  assign o_read_grant     = o_start_transfer && !hwrite_q;
  assign o_busy           = (state_q != IDLE);
  assign o_hwrite         = hwrite_q;
  assign o_haddr          = haddr_q;
  assign o_hsize          = hsize_q;

endmodule
